// File: rtl/soc_result_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : soc_result_mailbox
//  Description : Memory-mapped result mailbox on the core data bus. Holds the
//                test-program completion FLAG and RESULT word, raises a
//                sticky completion level and counts cycles from reset (or
//                clear) until completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_result_mailbox #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic [31:0] mem_flag,
    output logic [31:0] mem_result,
    output logic        signal,
    output logic [31:0] cycles
);

    localparam logic [1:0]  C_OFF_FLAG   = 2'd0;
    localparam logic [1:0]  C_OFF_RESULT = 2'd1;
    localparam logic [1:0]  C_OFF_CYCLES = 2'd2;
    localparam logic [1:0]  C_OFF_CTRL   = 2'd3;
    localparam logic [31:0] C_CYC_MAX    = 32'hFFFF_FFFF;

    logic        in_window;
    logic        gnt;
    logic [1:0]  offset;
    logic [31:0] be_mask;
    logic [31:0] flag_merged;
    logic [31:0] result_merged;
    logic        unused_addr_lsb;

    logic [31:0] flag_q,   flag_d;
    logic [31:0] result_q, result_d;
    logic [31:0] cycles_q, cycles_d;
    logic        signal_q, signal_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q,  rdata_d;

    // Address decode, grant and per-byte write merge (block never stalls)
    always_comb begin
        in_window     = (data_addr_i[31:4] == BASE_ADDR[31:4]);
        gnt           = data_req_i & in_window;
        offset        = data_addr_i[3:2];
        be_mask       = {{8{data_be_i[3]}}, {8{data_be_i[2]}},
                         {8{data_be_i[1]}}, {8{data_be_i[0]}}};
        flag_merged   = (flag_q   & ~be_mask) | (data_wdata_i & be_mask);
        result_merged = (result_q & ~be_mask) | (data_wdata_i & be_mask);
    end

    // Byte-lane bits of the address play no part in word decode
    assign unused_addr_lsb = ^data_addr_i[1:0];

    // Next-state: register writes, completion latch, cycle counter, response
    always_comb begin
        flag_d   = flag_q;
        result_d = result_q;
        signal_d = signal_q;
        rvalid_d = gnt;
        rdata_d  = 32'h0;
        // Counter runs until completion is visible, saturating at all-ones
        if (signal_q || (cycles_q == C_CYC_MAX)) begin
            cycles_d = cycles_q;
        end else begin
            cycles_d = cycles_q + 32'd1;
        end

        if (gnt) begin
            if (data_we_i) begin
                case (offset)
                    C_OFF_FLAG: begin
                        flag_d = flag_merged;
                        // Completion is sticky: a zero FLAG never drops it
                        if (flag_merged != 32'h0) begin
                            signal_d = 1'b1;
                        end
                    end
                    C_OFF_RESULT: begin
                        result_d = result_merged;
                    end
                    C_OFF_CTRL: begin
                        if (data_be_i[0] && data_wdata_i[0]) begin
                            flag_d   = 32'h0;
                            cycles_d = 32'h0;
                            signal_d = 1'b0;
                        end
                    end
                    default: begin
                        // CYCLES is read-only
                    end
                endcase
            end else begin
                // Reads return the value before any update at this edge
                case (offset)
                    C_OFF_FLAG:   rdata_d = flag_q;
                    C_OFF_RESULT: rdata_d = result_q;
                    C_OFF_CYCLES: rdata_d = cycles_q;
                    default:      rdata_d = 32'h0;
                endcase
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flag_q   <= 32'h0;
            result_q <= 32'h0;
            cycles_q <= 32'h0;
            signal_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            flag_q   <= flag_d;
            result_q <= result_d;
            cycles_q <= cycles_d;
            signal_q <= signal_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign mem_flag      = flag_q;
    assign mem_result    = result_q;
    assign signal        = signal_q;
    assign cycles        = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_result_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_result_mailbox
//  Description : Self-checking bench for soc_result_mailbox: vector table for
//                bus accesses plus directed sequences for counter timing,
//                back-to-back reads and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_result_mailbox;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        data_req_i = 1'b0;
    logic [31:0] data_addr_i = 32'h0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic [31:0] mem_flag;
    logic [31:0] mem_result;
    logic        signal;
    logic [31:0] cycles;

    int n_tests = 0;
    int n_fail  = 0;

    soc_result_mailbox #(.BASE_ADDR(BASE)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .data_req_i   (data_req_i),
        .data_addr_i  (data_addr_i),
        .data_we_i    (data_we_i),
        .data_be_i    (data_be_i),
        .data_wdata_i (data_wdata_i),
        .data_gnt_o   (data_gnt_o),
        .data_rvalid_o(data_rvalid_o),
        .data_rdata_o (data_rdata_o),
        .mem_flag     (mem_flag),
        .mem_result   (mem_result),
        .signal       (signal),
        .cycles       (cycles)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        e_gnt;
        logic        e_rvalid;
        logic        chk_rdata;
        logic [31:0] e_rdata;
        logic [31:0] e_flag;
        logic [31:0] e_result;
        logic        e_signal;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata);
        data_req_i   = req;
        data_addr_i  = addr;
        data_we_i    = we;
        data_be_i    = be;
        data_wdata_i = wdata;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    initial begin
        //            req  addr            we    be       wdata          gnt   rv    chkrd rdata          flag           result         sig
        vecs[0]  = '{1'b1, BASE + 32'h4,  1'b1, 4'hF,    32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[1]  = '{1'b1, BASE + 32'h0,  1'b1, 4'hF,    32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, BASE + 32'h4,  1'b1, 4'hF,    32'h1122_3344, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         32'h1122_3344, 1'b0};
        vecs[3]  = '{1'b1, BASE + 32'h4,  1'b1, 4'b0101, 32'hAAAA_AAAA, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         32'h11AA_33AA, 1'b0};
        vecs[4]  = '{1'b1, BASE + 32'h7,  1'b0, 4'hF,    32'h0,         1'b1, 1'b1, 1'b1, 32'h11AA_33AA, 32'h0,         32'h11AA_33AA, 1'b0};
        vecs[5]  = '{1'b1, BASE + 32'h4,  1'b1, 4'h0,    32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         32'h11AA_33AA, 1'b0};
        vecs[6]  = '{1'b1, BASE + 32'h10, 1'b0, 4'hF,    32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h11AA_33AA, 1'b0};
        vecs[7]  = '{1'b1, BASE + 32'h10, 1'b1, 4'hF,    32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         32'h11AA_33AA, 1'b0};
        vecs[8]  = '{1'b1, BASE + 32'h0,  1'b1, 4'b0010, 32'h0000_5A00, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0000_5A00, 32'h11AA_33AA, 1'b1};
        vecs[9]  = '{1'b1, BASE + 32'h0,  1'b1, 4'hF,    32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         32'h11AA_33AA, 1'b1};
        vecs[10] = '{1'b1, BASE + 32'h0,  1'b0, 4'hF,    32'h0,         1'b1, 1'b1, 1'b1, 32'h0,         32'h0,         32'h11AA_33AA, 1'b1};
        vecs[11] = '{1'b1, BASE + 32'hC,  1'b0, 4'hF,    32'h0,         1'b1, 1'b1, 1'b1, 32'h0,         32'h0,         32'h11AA_33AA, 1'b1};
        vecs[12] = '{1'b1, BASE + 32'hC,  1'b1, 4'hF,    32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         32'h11AA_33AA, 1'b1};
        vecs[13] = '{1'b1, BASE + 32'hC,  1'b1, 4'b1110, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         32'h11AA_33AA, 1'b1};
        vecs[14] = '{1'b1, BASE + 32'h4,  1'b1, 4'b1100, 32'hCAFE_0000, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         32'hCAFE_33AA, 1'b1};
        vecs[15] = '{1'b1, BASE + 32'hC,  1'b1, 4'b0001, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         32'hCAFE_33AA, 1'b0};

        // ---------------- reset and idle counting ----------------
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("reset_rvalid", {31'h0, data_rvalid_o}, 32'h0);
        check("reset_rdata",  data_rdata_o, 32'h0);
        check("reset_flag",   mem_flag,     32'h0);
        check("reset_result", mem_result,   32'h0);
        check("reset_signal", {31'h0, signal}, 32'h0);
        check("reset_cycles", cycles,       32'h0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_i);
            check($sformatf("idle_cycles_%0d", k), cycles, k);
            check($sformatf("idle_signal_%0d", k), {31'h0, signal}, 32'h0);
        end

        // ---------------- vector table, back-to-back ----------------
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].req, vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata);
            #1;
            check($sformatf("v%0d_gnt", i), {31'h0, data_gnt_o}, {31'h0, vecs[i].e_gnt});
            @(negedge clk_i);
            check($sformatf("v%0d_rvalid", i), {31'h0, data_rvalid_o}, {31'h0, vecs[i].e_rvalid});
            if (vecs[i].chk_rdata)
                check($sformatf("v%0d_rdata", i), data_rdata_o, vecs[i].e_rdata);
            check($sformatf("v%0d_flag", i),   mem_flag,   vecs[i].e_flag);
            check($sformatf("v%0d_result", i), mem_result, vecs[i].e_result);
            check($sformatf("v%0d_signal", i), {31'h0, signal}, {31'h0, vecs[i].e_signal});
        end
        idle();

        // ---------------- counter restart after clear ----------------
        check("clr_cycles0", cycles, 32'h0);
        @(negedge clk_i);
        check("clr_cycles1", cycles, 32'd1);
        drive(1'b1, BASE + 32'h8, 1'b0, 4'hF, 32'h0);
        @(negedge clk_i);
        idle();
        check("cyc_read_rvalid", {31'h0, data_rvalid_o}, 32'h1);
        check("cyc_read_preinc", data_rdata_o, 32'd1);
        check("clr_cycles2", cycles, 32'd2);
        @(negedge clk_i);
        check("cyc_read_one_shot", {31'h0, data_rvalid_o}, 32'h0);
        check("clr_cycles3", cycles, 32'd3);

        // ---------------- completion with FLAG=1 ----------------
        drive(1'b1, BASE, 1'b1, 4'hF, 32'h1);
        @(negedge clk_i);
        idle();
        check("done_signal", {31'h0, signal}, 32'h1);
        check("done_flag",   mem_flag, 32'h1);
        check("done_cycles", cycles,   32'd4);
        check("done_result", mem_result, 32'hCAFE_33AA);
        repeat (2) @(negedge clk_i);
        check("frozen_cycles", cycles, 32'd4);

        // ---------------- four back-to-back reads ----------------
        begin
            logic [31:0] exp_rd[4];
            exp_rd[0] = 32'h1;
            exp_rd[1] = 32'hCAFE_33AA;
            exp_rd[2] = 32'd4;
            exp_rd[3] = 32'h0;
            for (int j = 0; j < 4; j++) begin
                drive(1'b1, BASE + 32'(j * 4), 1'b0, 4'hF, 32'h0);
                @(negedge clk_i);
                check($sformatf("b2b_rvalid_%0d", j), {31'h0, data_rvalid_o}, 32'h1);
                check($sformatf("b2b_rdata_%0d", j), data_rdata_o, exp_rd[j]);
            end
            idle();
            @(negedge clk_i);
            check("b2b_rvalid_end", {31'h0, data_rvalid_o}, 32'h0);
        end

        // ---------------- asynchronous reset mid-response ----------------
        drive(1'b1, BASE, 1'b0, 4'hF, 32'h0);
        @(negedge clk_i);
        idle();
        check("pre_rst_rvalid", {31'h0, data_rvalid_o}, 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_rvalid", {31'h0, data_rvalid_o}, 32'h0);
        check("rst_rdata",  data_rdata_o, 32'h0);
        check("rst_flag",   mem_flag,     32'h0);
        check("rst_result", mem_result,   32'h0);
        check("rst_signal", {31'h0, signal}, 32'h0);
        check("rst_cycles", cycles,       32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
